rca_mul_ctrl: RTL and testbench

Sequential shift-and-add multiplier controller that time-shares one external WIDTH-bit ripple-carry adder (ports A, B, Sum, Cout; no carry-in).
- Computes an unsigned WIDTH x WIDTH -> 2*WIDTH product over WIDTH iterations, one adder pass per clock.
- Sits in the Rechenwerk next to the adder slice.
- Drives the adder operands and consumes Sum/Cout combinationally within the same cycle.

---
 rtl/rca_mul_ctrl_if.sv | 26 ++
 rtl/rca_mul_ctrl.sv | 106 ++++++++++
 tb/tb_rca_mul_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/rca_mul_ctrl_if.sv
// Handshake and adder-slice bundle for the shift-and-add multiplier controller.
// slave = controller side, master = requester/adder side.
interface rca_mul_ctrl_if #(
  parameter int WIDTH = 4
);
  logic                 Start;
  logic [WIDTH-1:0]     A;
  logic [WIDTH-1:0]     B;
  logic                 Busy;
  logic                 Done;
  logic [2*WIDTH-1:0]   Product;
  logic [WIDTH-1:0]     Add_A;
  logic [WIDTH-1:0]     Add_B;
  logic [WIDTH-1:0]     Add_Sum;
  logic                 Add_Cout;

  modport slave (
    input  Start, A, B, Add_Sum, Add_Cout,
    output Busy, Done, Product, Add_A, Add_B
  );

  modport master (
    output Start, A, B, Add_Sum, Add_Cout,
    input  Busy, Done, Product, Add_A, Add_B
  );
endinterface

// File: rtl/rca_mul_ctrl.sv
// Shift-and-add multiplier controller time-sharing one external ripple-carry adder.
// Optional MUL_ZERO_BYPASS_EN: a zero operand skips the adder passes and finishes in one cycle.
//
// state | meaning
// IDLE  | waiting for Start, adder operands parked at 0
// CALC  | one adder pass per cycle, WIDTH passes
// DONE  | Product loaded, Done pulse, back to IDLE next cycle
module rca_mul_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  rca_mul_ctrl_if.slave bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [WIDTH-1:0]     m_q, m_d;
  logic [2*WIDTH-1:0]   p_q, p_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   product_q, product_d;
  logic [WIDTH-1:0]     add_a, add_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      m_q       <= '0;
      p_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      m_q       <= m_d;
      p_q       <= p_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  // Adder operands come only from registered state so there is no path from Start.
  always_comb begin
    add_a = '0;
    add_b = '0;
    if (state_q == CALC) begin
      add_a = p_q[2*WIDTH-1:WIDTH];
      add_b = p_q[0] ? m_q : '0;
    end
  end

  always_comb begin
    state_d   = state_q;
    m_d       = m_q;
    p_d       = p_q;
    cnt_d     = cnt_q;
    product_d = product_q;
    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          m_d   = bus.A;
          p_d   = {{WIDTH{1'b0}}, bus.B};
          cnt_d = '0;
`ifdef MUL_ZERO_BYPASS_EN
          if ((bus.A == '0) || (bus.B == '0)) begin
            p_d       = '0;
            product_d = '0;
            state_d   = DONE;
          end else begin
            state_d = CALC;
          end
`else
          state_d = CALC;
`endif
        end
      end
      CALC: begin
        // Cout lands in the top bit, so the shifted accumulator never loses a carry.
        p_d   = {bus.Add_Cout, bus.Add_Sum, p_q[WIDTH-1:1]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CNT_LAST) begin
          product_d = p_d;
          state_d   = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.Add_A   = add_a;
  assign bus.Add_B   = add_b;
  assign bus.Busy    = (state_q != IDLE);
  assign bus.Done    = (state_q == DONE);
  assign bus.Product = product_q;

endmodule

// File: tb/tb_rca_mul_ctrl.sv
// Self-checking bench for rca_mul_ctrl with a behavioural adder and an arithmetic reference model.
module tb_rca_mul_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  rca_mul_ctrl_if #(.WIDTH(W)) bus ();

  rca_mul_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign {bus.Add_Cout, bus.Add_Sum} = {1'b0, bus.Add_A} + {1'b0, bus.Add_B};

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit zero_bypass(input int a, input int b);
`ifdef MUL_ZERO_BYPASS_EN
    return (a == 0) || (b == 0);
`else
    return 1'b0;
`endif
  endfunction

  function automatic int exp_lat(input int a, input int b);
    return zero_bypass(a, b) ? 1 : W + 1;
  endfunction

  // Reference model: rem = busy cycles left including the current one.
  int rem, ma, mb, mprod;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem <= 0; ma <= 0; mb <= 0; mprod <= 0;
    end else if (rem == 0) begin
      if (bus.Start === 1'b1) begin
        ma <= int'(bus.A);
        mb <= int'(bus.B);
        if (zero_bypass(int'(bus.A), int'(bus.B))) begin
          rem <= 1;
          mprod <= 0;
        end else begin
          rem <= W + 1;
        end
      end
    end else begin
      rem <= rem - 1;
      if (rem == 2) mprod <= ma * mb;
    end
  end

  // Pass j adds (A if bit j-1 of B) to the upper half of the partial product A*(B mod 2^(j-1)).
  always @(negedge clk) begin
    int j, ea, eb;
    if (chk_en) begin
      ea = 0;
      eb = 0;
      if (rem >= 2) begin
        j  = W + 2 - rem;
        ea = (ma * (mb % (1 << (j - 1)))) >> (j - 1);
        eb = ((mb >> (j - 1)) & 1) != 0 ? ma : 0;
      end
      check("m_busy",    32'(bus.Busy),    32'(rem > 0));
      check("m_done",    32'(bus.Done),    32'(rem == 1));
      check("m_product", 32'(bus.Product), 32'(mprod));
      check("m_add_a",   32'(bus.Add_A),   32'(ea));
      check("m_add_b",   32'(bus.Add_B),   32'(eb));
    end
  end

  task automatic run_op(input int a, input int b, output int lat, output int prod, output int busy);
    @(posedge clk); #1;
    bus.A = W'(a);
    bus.B = W'(b);
    bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    lat = 0; prod = -1; busy = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (bus.Busy) busy++;
      if (bus.Done) begin
        lat = i;
        prod = int'(bus.Product);
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      check("done_pulse", 32'(bus.Done), 32'(0));
    end
  endtask

  initial begin
    int lat, prod, busy, dones;
    int exp_a[4];
    int exp_b[4];
    exp_a = '{0, 2, 3, 1};
    exp_b = '{5, 5, 0, 0};
    bus.Start = 1'b0;
    bus.A = '0;
    bus.B = '0;

    repeat (2) @(negedge clk);
    check("rst_busy",    32'(bus.Busy),    32'(0));
    check("rst_done",    32'(bus.Done),    32'(0));
    check("rst_product", 32'(bus.Product), 32'(0));
    check("rst_add_a",   32'(bus.Add_A),   32'(0));
    check("rst_add_b",   32'(bus.Add_B),   32'(0));
    chk_en = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b1;

    run_op(15, 15, lat, prod, busy);
    check("t1_product", 32'(prod), 32'h0E1);
    check("t1_latency", 32'(lat),  32'(5));
    check("t1_busy",    32'(busy), 32'(5));

    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(a, b, lat, prod, busy);
        check("exh_product", 32'(prod), 32'(a * b));
        check("exh_latency", 32'(lat),  32'(exp_lat(a, b)));
      end
    end

    // Start during CALC must be ignored.
    @(posedge clk); #1;
    bus.A = 4'd9; bus.B = 4'd6; bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0; bus.A = 4'd3; bus.B = 4'd3;
    @(posedge clk); #1;
    bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (bus.Done) begin
        dones++;
        if (dones == 1) check("ign_product", 32'(bus.Product), 32'h36);
      end
    end
    check("ign_dones", 32'(dones), 32'(1));

    // Reset in CALC at cnt==2 aborts and clears Product.
    @(posedge clk); #1;
    bus.A = 4'd13; bus.B = 4'd11; bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    check("abort_product", 32'(bus.Product), 32'(0));
    check("abort_busy",    32'(bus.Busy),    32'(0));
    check("abort_done",    32'(bus.Done),    32'(0));
    @(posedge clk); #1;
    rst_n = 1'b1;
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.Done) dones++;
    end
    check("abort_no_done", 32'(dones), 32'(0));
    run_op(2, 3, lat, prod, busy);
    check("post_abort_product", 32'(prod), 32'(6));

    run_op(0, 7, lat, prod, busy);
    check("zero_product", 32'(prod), 32'(0));
`ifdef MUL_ZERO_BYPASS_EN
    check("zero_latency", 32'(lat), 32'(1));
`else
    check("zero_latency", 32'(lat), 32'(5));
`endif

    // Adder port sequence for 5 x 3.
    @(posedge clk); #1;
    bus.A = 4'd5; bus.B = 4'd3; bus.Start = 1'b1;
    @(posedge clk); #1;
    bus.Start = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("port_add_a", 32'(bus.Add_A), 32'(exp_a[i]));
      check("port_add_b", 32'(bus.Add_B), 32'(exp_b[i]));
    end
    @(negedge clk);
    check("port_done",      32'(bus.Done),    32'(1));
    check("port_product",   32'(bus.Product), 32'(15));
    check("port_done_a",    32'(bus.Add_A),   32'(0));
    check("port_done_b",    32'(bus.Add_B),   32'(0));
    @(negedge clk);
    check("port_idle_a",    32'(bus.Add_A),   32'(0));
    check("port_idle_b",    32'(bus.Add_B),   32'(0));

    // Start held high: a new operation on every return to IDLE.
    @(posedge clk); #1;
    bus.A = 4'd2; bus.B = 4'd2; bus.Start = 1'b1;
    dones = 0;
    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      if (bus.Done) begin
        dones++;
        check("held_product", 32'(bus.Product), 32'(4));
      end
    end
    check("held_dones", 32'(dones), 32'(3));
    @(posedge clk); #1;
    bus.Start = 1'b0;
    repeat (10) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
